control_sequencer: RTL
======================

# control_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit CPU datapath. It sits directly upstream of the shared-bus multiplexer: it generates the 3-bit bus `selector_line` code that picks which source drives the internal bus each cycle. It also generates the load, increment and write strobes that let the PC, MAR, IR, register file and memory consume the bus value at the next rising edge.

## Interface
- `SEL_IDLE`, default 3'd7: selector code driven when no source owns the bus. The bus mux outputs high-Z for it.
- Bus source codes, shared defines: `GENERAL_REGISTERS`=3'd0, `PC`=3'd1, `IR`=3'd2, `MAR`=3'd3, `MEMORY`=3'd4.
- `clk` in 1: single clock. All state changes occur on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: level. High permits starting the next instruction.
- `ir_data` in 8: current IR contents. Opcode = [7:5], rd = [3:2], rs = [1:0], bit 4 reserved/ignored.
- `zero_flag` in 1: ALU zero flag, used by JZ.
- `selector_line` out 3: bus source select to the mux.
- `mar_load` out 1: MAR <= bus.
- `ir_load` out 1: IR <= bus.
- `pc_inc` out 1: PC <= PC+1, mod 256.
- `pc_load` out 1: PC <= bus.
- `reg_write` out 1: regfile[`reg_waddr`] <= bus.
- `reg_waddr` out 2: register write address.
- `reg_raddr` out 2: register read address driving the `GENERAL_REGISTERS` source.
- `mem_write` out 1: mem[MAR] <= bus.
- `halted` out 1: high while in HALT.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.

## Operation
- Moore FSM. Outputs decode from the registered state, plus `ir_data` fields for register addresses.
- Any strobe not listed for a state is 0. `selector_line` = `SEL_IDLE` unless listed.
- States: IDLE, F0, F1, DEC, E0, E1, E2, HALT.
- Reset: state IDLE. All strobes 0, `selector_line`=3'd7, `halted`=0, `instr_done`=0, `reg_waddr`/`reg_raddr`=0.
- IDLE: go to F0 if `run`, else stay.
- F0: sel=`PC`, `mar_load`. Go to F1.
- F1: sel=`MEMORY`, `ir_load`, `pc_inc`. Go to DEC.
- DEC: no strobes. Samples opcode (and `zero_flag` for JZ) and branches.
- Opcode paths:
  - 0 NOP: end in DEC.
  - 1 LDI rd,#imm: E0 sel=`PC`, `mar_load`. E1 sel=`MEMORY`, `reg_write`(rd), `pc_inc`. End.
  - 2 LD rd,[a]: E0 as LDI. E1 sel=`MEMORY`, `mar_load`, `pc_inc`. E2 sel=`MEMORY`, `reg_write`(rd). End.
  - 3 ST rs,[a]: E0/E1 as LD. E2 sel=`GENERAL_REGISTERS`, `reg_raddr`=rs, `mem_write`. End.
  - 4 MOV rd,rs: E0 sel=`GENERAL_REGISTERS`, `reg_raddr`=rs, `reg_write`(rd). End.
  - 5 JMP a: E0 sel=`PC`, `mar_load`. E1 sel=`MEMORY`, `pc_load`. End.
  - 6 JZ a:
    - `zero_flag`=1 at DEC: same as JMP.
    - `zero_flag`=0 at DEC: E0 `pc_inc` only (skip operand). End.
  - 7 HLT: go to HALT. Stays there until reset; `run` is ignored.
- End of instruction:
  - `instr_done`=1 in the ending state; for NOP that is DEC.
  - Next state is F0 if `run`=1 in that cycle, else IDLE.
  - HLT pulses `instr_done` in DEC.
- Never more than one of `mar_load`/`ir_load`/`pc_load`/`reg_write`/`mem_write` sourced from a conflicting bus value. `pc_inc` and `pc_load` are never both 1.

## Timing
- Memory read is combinational from MAR: data is valid in the cycle after `mar_load`.
- Cycles per instruction, F0 through the end state: NOP 3, MOV 4, LDI 5, JMP 5, JZ taken 5, JZ not-taken 4, LD 6, ST 6, HLT 3 (then HALT).
- `run` is sampled only in IDLE and end-of-instruction cycles. Deasserting it never aborts an instruction.
- Reset mid-instruction:
  - Immediate return to IDLE.
  - All strobes drop asynchronously.
  - No partial write occurs after reset assertion.
- Back-to-back instructions with `run` held high have no idle gap: an end state is followed directly by F0.

## Test plan
- Reset with `run`=0 → all strobes 0, `selector_line`=3'd7, stays in IDLE. Assert reset in E2 of ST → `mem_write` drops immediately, state IDLE.
- Program LDI r1,#0x5A; MOV r2,r1; HLT with `run`=1 → r1=r2=0x5A. `instr_done` at cycles 5, 9, 12. `halted`=1 thereafter; `run` toggles ignored.
- LD r0,[0x80] where mem[0x80]=0x33; then ST r0,[0x81] → mem[0x81]=0x33, PC=4, each instruction 6 cycles.
- JMP 0x10 at PC=0 → PC=0x10 after 5 cycles. JZ 0x20 with `zero_flag`=0 → PC advances by 2 in 4 cycles; with `zero_flag`=1 → PC=0x20.
- PC wrap: NOP at 0xFF → PC=0x00.
- `run` dropped during LD E1 → LD completes, then IDLE. Re-assert `run` → F0 next cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM driving bus select and datapath strobes
module control_sequencer #(
   parameter logic [2:0] SEL_IDLE = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] ir_data,
   input  logic       zero_flag,
   output logic [2:0] selector_line,
   output logic       mar_load,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       reg_write,
   output logic [1:0] reg_waddr,
   output logic [1:0] reg_raddr,
   output logic       mem_write,
   output logic       halted,
   output logic       instr_done
);
   localparam logic [2:0] SEL_GPR = 3'd0;
   localparam logic [2:0] SEL_PC  = 3'd1;
   localparam logic [2:0] SEL_MEM = 3'd4;
   typedef enum logic [2:0] {IDLE, F0, F1, DEC, E0, E1, E2, HALT} state_e;
   typedef enum logic [2:0] {NOP, LDI, LD, ST, MOV, JMP, JZ, HLT} op_e;
   state_e state_q, state_d;
   op_e    op_q, op_d;
   logic   take_q, take_d;
   logic   fin;
   logic   unused_rsvd;
   assign unused_rsvd = ir_data[4];
   // state, latched opcode and JZ decision; async reset drops all strobes at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= NOP;
         take_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         take_q  <= take_d;
      end
   end
   // next state and Moore outputs; fin marks the last cycle of an instruction
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      take_d        = take_q;
      selector_line = SEL_IDLE;
      mar_load      = 1'b0;
      ir_load       = 1'b0;
      pc_inc        = 1'b0;
      pc_load       = 1'b0;
      reg_write     = 1'b0;
      reg_waddr     = 2'd0;
      reg_raddr     = 2'd0;
      mem_write     = 1'b0;
      halted        = 1'b0;
      instr_done    = 1'b0;
      fin           = 1'b0;
      case (state_q)
         IDLE: state_d = run ? F0 : IDLE;
         F0: begin
            selector_line = SEL_PC;
            mar_load      = 1'b1;
            state_d       = F1;
         end
         F1: begin
            selector_line = SEL_MEM;
            ir_load       = 1'b1;
            pc_inc        = 1'b1;
            state_d       = DEC;
         end
         DEC: begin
            op_d   = op_e'(ir_data[7:5]);
            take_d = zero_flag;
            if (op_d == NOP) fin = 1'b1;
            else if (op_d == HLT) begin
               instr_done = 1'b1;
               state_d    = HALT;
            end else state_d = E0;
         end
         E0: begin
            state_d = E1;
            if (op_q == MOV) begin
               selector_line = SEL_GPR;
               reg_raddr     = ir_data[1:0];
               reg_write     = 1'b1;
               reg_waddr     = ir_data[3:2];
               fin           = 1'b1;
            end else if (op_q == JZ && !take_q) begin
               pc_inc = 1'b1;
               fin    = 1'b1;
            end else begin
               selector_line = SEL_PC;
               mar_load      = 1'b1;
            end
         end
         E1: begin
            selector_line = SEL_MEM;
            state_d       = E2;
            if (op_q == LDI) begin
               reg_write = 1'b1;
               reg_waddr = ir_data[3:2];
               pc_inc    = 1'b1;
               fin       = 1'b1;
            end else if (op_q == LD || op_q == ST) begin
               mar_load = 1'b1;
               pc_inc   = 1'b1;
            end else begin
               pc_load = 1'b1;
               fin     = 1'b1;
            end
         end
         E2: begin
            fin = 1'b1;
            if (op_q == ST) begin
               selector_line = SEL_GPR;
               reg_raddr     = ir_data[1:0];
               mem_write     = 1'b1;
            end else begin
               selector_line = SEL_MEM;
               reg_write     = 1'b1;
               reg_waddr     = ir_data[3:2];
            end
         end
         HALT: halted = 1'b1;
      endcase
      if (fin) begin
         instr_done = 1'b1;
         state_d    = run ? F0 : IDLE;
      end
   end
endmodule
